lc3_mem_ctrl: RTL and testbench

Parametrised MAR/MDR memory unit with a wait-state memory controller for the LC-3 datapath. It replaces the fixed single-cycle two-port RAM path with a request/ready (MIO.EN / R) handshake, a configurable access latency and address-range checking. An internal single-clock RAM array also serves a debug/loader port.

---
 rtl/lc3_mem_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: MAR/MDR memory unit for the LC-3 datapath with a wait-state
// memory controller (MIO.EN / R handshake), address-range checking and an
// internal single-clock RAM that also serves a debug/loader port.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   bus_in              datapath bus (source for MAR and MDR loads)
//   ld_mar, ld_mdr      register load strobes
//   sel_mdr             MDR source: 1 = last core read data, 0 = bus_in
//   mem_en, mem_we      core access request and write qualifier
//   mar_out, mdr_out    register contents
//   mem_ready           one-cycle access-complete pulse (R)
//   mem_err             out-of-range flag, valid with mem_ready
//   busy                controller is not idle
//   dbg_addr/wdata/we   debug port address, write data, write enable
//   dbg_rdata           debug read data, one cycle after dbg_addr
module lc3_mem_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     bus_in,
  input  logic                  ld_mar,
  input  logic                  ld_mdr,
  input  logic                  sel_mdr,
  input  logic                  mem_en,
  input  logic                  mem_we,
  output logic [ADDR_W-1:0]     mar_out,
  output logic [DATA_W-1:0]     mdr_out,
  output logic                  mem_ready,
  output logic                  mem_err,
  output logic                  busy,
  input  logic [DEPTH_LOG2-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  input  logic                  dbg_we,
  output logic [DATA_W-1:0]     dbg_rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              mem_ready_q, mem_ready_d;
  logic              mem_err_q, mem_err_d;
  logic              busy_q, busy_d;

  logic                  core_wr;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] core_idx;

  assign in_range = (addr_q[ADDR_W-1:DEPTH_LOG2] == '0);
  assign core_idx = addr_q[DEPTH_LOG2-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    mar_d       = mar_q;
    mdr_d       = mdr_q;
    rdata_d     = rdata_q;
    mem_ready_d = 1'b0;
    mem_err_d   = 1'b0;
    core_wr     = 1'b0;
    dbg_rdata_d = mem[dbg_addr];

    if (ld_mar) mar_d = bus_in[ADDR_W-1:0];
    if (ld_mdr) mdr_d = sel_mdr ? rdata_q : bus_in;

    case (state_q)
      S_IDLE: begin
        if (mem_en) begin
          addr_d  = mar_q;
          wdata_d = mdr_q;
          we_d    = mem_we;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Commit edge: R and err are registered here so they appear
          // during the DONE cycle.
          state_d     = S_DONE;
          mem_ready_d = 1'b1;
          if (in_range) begin
            if (we_q) core_wr = 1'b1;
            else      rdata_d = mem[core_idx];
          end else begin
            mem_err_d = 1'b1;
            if (!we_q) rdata_d = '0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      mar_q       <= '0;
      mdr_q       <= '0;
      rdata_q     <= '0;
      dbg_rdata_q <= '0;
      mem_ready_q <= 1'b0;
      mem_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      rdata_q     <= rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      mem_ready_q <= mem_ready_d;
      mem_err_q   <= mem_err_d;
      busy_q      <= busy_d;
    end
  end

  // Core write is ordered after the debug write so it wins a same-address
  // collision; a reset on the commit edge suppresses the core write.
  always_ff @(posedge clk) begin
    if (dbg_we) mem[dbg_addr] <= dbg_wdata;
    if (core_wr && reset) mem[core_idx] <= wdata_q;
  end

  assign mar_out   = mar_q;
  assign mdr_out   = mdr_q;
  assign mem_ready = mem_ready_q;
  assign mem_err   = mem_err_q;
  assign busy      = busy_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
module tb_lc3_mem_ctrl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus_in;
  logic        ld_mar, ld_mdr, sel_mdr, mem_en, mem_we;
  logic [15:0] mar_out, mdr_out;
  logic        mem_ready, mem_err, busy;
  logic [9:0]  dbg_addr;
  logic [15:0] dbg_wdata;
  logic        dbg_we;
  logic [15:0] dbg_rdata;

  // Second instance with zero wait states
  logic [15:0] b_bus_in;
  logic        b_ld_mar, b_ld_mdr, b_sel_mdr, b_mem_en, b_mem_we;
  logic [15:0] b_mar_out, b_mdr_out;
  logic        b_mem_ready, b_mem_err, b_busy;
  logic [9:0]  b_dbg_addr;
  logic [15:0] b_dbg_wdata;
  logic        b_dbg_we;
  logic [15:0] b_dbg_rdata;

  int errors = 0;
  int checks = 0;

  logic [15:0] model [1024];

  always #5 clk = ~clk;

  lc3_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_STATES(W)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .sel_mdr(sel_mdr), .mem_en(mem_en), .mem_we(mem_we), .mar_out(mar_out),
    .mdr_out(mdr_out), .mem_ready(mem_ready), .mem_err(mem_err), .busy(busy),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_we(dbg_we), .dbg_rdata(dbg_rdata)
  );

  lc3_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus_in(b_bus_in), .ld_mar(b_ld_mar), .ld_mdr(b_ld_mdr),
    .sel_mdr(b_sel_mdr), .mem_en(b_mem_en), .mem_we(b_mem_we), .mar_out(b_mar_out),
    .mdr_out(b_mdr_out), .mem_ready(b_mem_ready), .mem_err(b_mem_err), .busy(b_busy),
    .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata), .dbg_we(b_dbg_we), .dbg_rdata(b_dbg_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_mar(input logic [15:0] v);
    bus_in = v; ld_mar = 1'b1; tick(); ld_mar = 1'b0;
  endtask

  task automatic load_mdr_bus(input logic [15:0] v);
    bus_in = v; sel_mdr = 1'b0; ld_mdr = 1'b1; tick(); ld_mdr = 1'b0;
  endtask

  task automatic load_mdr_rdata();
    sel_mdr = 1'b1; ld_mdr = 1'b1; tick(); ld_mdr = 1'b0; sel_mdr = 1'b0;
  endtask

  // One core access on the main instance: returns edges from the request
  // edge until R is seen (or -1), and the error flag seen with R.
  task automatic do_access(input logic we, output int lat, output logic err);
    mem_we = we; mem_en = 1'b1;
    tick();
    mem_en = 1'b0;
    chk("busy_after_req", busy, 1);
    lat = -1; err = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (mem_ready) begin lat = n; err = mem_err; break; end
    end
    tick();
    chk("ready_one_cycle", mem_ready, 0);
    chk("idle_after_done", busy, 0);
  endtask

  task automatic dbg_read(input logic [9:0] a, input logic [15:0] exp, input string tag);
    dbg_addr = a; dbg_we = 1'b0; tick();
    chk(tag, dbg_rdata, exp);
  endtask

  initial begin
    int lat;
    logic err;
    logic [15:0] addr, data, old9;
    logic we, inr;
    int rcount;

    reset = 1'b0; bus_in = '0; ld_mar = 0; ld_mdr = 0; sel_mdr = 0; mem_en = 0; mem_we = 0;
    dbg_addr = '0; dbg_wdata = '0; dbg_we = 0;
    b_bus_in = '0; b_ld_mar = 0; b_ld_mdr = 0; b_sel_mdr = 0; b_mem_en = 0; b_mem_we = 0;
    b_dbg_addr = '0; b_dbg_wdata = '0; b_dbg_we = 0;
    tick(); tick();

    chk("rst_mar", mar_out, 0);
    chk("rst_mdr", mdr_out, 0);
    chk("rst_ready", mem_ready, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    reset = 1'b1;

    // Preload every word with random data so later scans have a known image
    for (int a = 0; a < 1024; a++) begin
      dbg_addr = 10'(a); dbg_wdata = 16'($urandom); dbg_we = 1'b1;
      model[a] = dbg_wdata;
      tick();
    end
    dbg_we = 1'b0;

    // 1: debug write then core read
    dbg_addr = 10'd5; dbg_wdata = 16'h1234; dbg_we = 1'b1; tick(); dbg_we = 1'b0;
    model[5] = 16'h1234;
    load_mar(16'd5);
    chk("t1_mar", mar_out, 16'd5);
    do_access(1'b0, lat, err);
    chk("t1_latency", lat, W + 1);
    chk("t1_err", err, 0);
    load_mdr_rdata();
    chk("t1_mdr", mdr_out, 16'h1234);

    // 2: core write then debug read
    load_mar(16'h0007);
    load_mdr_bus(16'hBEEF);
    chk("t2_mdr", mdr_out, 16'hBEEF);
    do_access(1'b1, lat, err);
    chk("t2_latency", lat, W + 1);
    chk("t2_err", err, 0);
    model[7] = 16'hBEEF;
    dbg_read(10'd7, 16'hBEEF, "t2_dbg");

    // 3: mem_en held high; R once per W+3 cycles, never back to back
    load_mar(16'd5);
    mem_we = 1'b0; mem_en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("t3_ready_c%0d", i), mem_ready,
          (i >= W + 2 && ((i - (W + 2)) % (W + 3)) == 0) ? 1 : 0);
    end
    mem_en = 1'b0;
    rcount = 0;
    for (int i = 0; i < 30 && busy; i++) begin tick(); rcount++; end
    chk("t3_drain", busy, 0);

    // 4: out-of-range read and write
    load_mar(16'h8000);
    do_access(1'b0, lat, err);
    chk("t4_rd_latency", lat, W + 1);
    chk("t4_rd_err", err, 1);
    load_mdr_rdata();
    chk("t4_rdata_zero", mdr_out, 0);
    load_mdr_bus(16'hDEAD);
    do_access(1'b1, lat, err);
    chk("t4_wr_err", err, 1);

    // 5: debug write to the same word on the core commit edge
    load_mar(16'd3);
    load_mdr_bus(16'hAAAA);
    mem_we = 1'b1; mem_en = 1'b1; tick(); mem_en = 1'b0;
    for (int i = 0; i < W; i++) tick();
    dbg_addr = 10'd3; dbg_wdata = 16'h5555; dbg_we = 1'b1;
    tick();
    dbg_we = 1'b0;
    chk("t5_ready", mem_ready, 1);
    model[3] = 16'hAAAA;
    tick();
    dbg_read(10'd3, 16'hAAAA, "t5_collision");

    // 6: reset during a write access aborts it
    old9 = model[9];
    load_mar(16'd9);
    load_mdr_bus(~old9);
    mem_we = 1'b1; mem_en = 1'b1; tick(); mem_en = 1'b0;
    tick();
    reset = 1'b0; tick(); reset = 1'b1;
    chk("t6_busy", busy, 0);
    chk("t6_ready", mem_ready, 0);
    tick(); tick(); tick();
    dbg_read(10'd9, old9, "t6_no_write");

    // 6b: zero wait states on the second instance
    b_dbg_addr = 10'd2; b_dbg_wdata = 16'h4321; b_dbg_we = 1'b1; tick(); b_dbg_we = 1'b0;
    b_bus_in = 16'd2; b_ld_mar = 1'b1; tick(); b_ld_mar = 1'b0;
    b_mem_we = 1'b0; b_mem_en = 1'b1; tick(); b_mem_en = 1'b0;
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      if (n > 1 || 1) begin end
      tick();
      if (b_mem_ready) begin lat = n; break; end
    end
    chk("t6b_latency", lat, 1);
    tick();
    b_sel_mdr = 1'b1; b_ld_mdr = 1'b1; tick(); b_ld_mdr = 1'b0;
    chk("t6b_mdr", b_mdr_out, 16'h4321);

    // Random transactions against the array model
    for (int t = 0; t < 16; t++) begin
      inr  = ($urandom_range(0, 3) != 0);
      addr = inr ? 16'($urandom_range(0, 1023))
                 : (16'($urandom_range(0, 1023)) | (16'd1 << $urandom_range(10, 15)));
      data = 16'($urandom);
      we   = 1'($urandom_range(0, 1));
      load_mar(addr);
      chk("rnd_mar", mar_out, addr);
      load_mdr_bus(data);
      do_access(we, lat, err);
      chk("rnd_latency", lat, W + 1);
      chk("rnd_err", err, inr ? 0 : 1);
      if (we) begin
        if (inr) model[addr[9:0]] = data;
      end else begin
        load_mdr_rdata();
        chk("rnd_rdata", mdr_out, inr ? model[addr[9:0]] : 16'h0000);
      end
    end

    // Full image scan via the debug port
    for (int a = 0; a < 1024; a++)
      dbg_read(10'(a), model[a], $sformatf("scan_%0d", a));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
